fifo_drain_stream: RTL and testbench

//  Read-side master for the 8-bit synchronous FIFO. Issues RDEN whenever the FIFO is non-empty
//  and it has room, captures data_out, and re-presents each word on a valid/ready stream.
//  A 2-entry output buffer absorbs the FIFO's 1-cycle read latency so back-to-back transfers run at full rate.

---
 rtl/fifo_drain_stream.sv | 61 ++++++
 tb/tb_fifo_drain_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_stream.sv
// fifo_drain_stream: drains an 8-bit synchronous FIFO into a valid/ready stream through a 2-entry buffer.
// Define FIFO_DRAIN_PARITY_EN to add the even-parity output m_parity.
module fifo_drain_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rden,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
`ifdef FIFO_DRAIN_PARITY_EN
    output logic              m_parity,
`endif
    output logic [CNT_W-1:0]  words_out
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state, state_nxt;
    logic [1:0] occ;
    logic inflt, hd, pop;
    logic [DATA_W-1:0] mem [2];
    assign pop = m_valid & m_ready;
    assign m_valid = occ != 2'd0;
    assign m_data = m_valid ? mem[hd] : '0;
    assign busy = state != IDLE || occ != 2'd0 || inflt;
`ifdef FIFO_DRAIN_PARITY_EN
    assign m_parity = m_valid & ^m_data;
`endif
    // a read may only be issued if its word is guaranteed a buffer slot when it lands
    assign fifo_rden = !rst && state == RUN && enable && !fifo_empty &&
                       (3'(occ) + 3'(inflt) - 3'(pop) < 3'd2);
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (enable ? RUN : IDLE) :
                    state == RUN  ? (enable ? RUN : STOP) :
                    enable ? RUN : (occ == 2'd0 && !inflt) ? IDLE : STOP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            occ       <= 2'd0;
            inflt     <= 1'b0;
            hd        <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
            words_out <= '0;
        end else begin
            state <= state_nxt;
            inflt <= fifo_rden;
            if (inflt) mem[hd ^ occ[0]] <= fifo_data;
            if (pop) hd <= ~hd;
            occ       <= occ + 2'(inflt) - 2'(pop);
            words_out <= words_out + CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_drain_stream.sv
// tb_fifo_drain_stream: FIFO model plus order/count scoreboard around fifo_drain_stream.
module tb_fifo_drain_stream;
    logic clk = 0, rst = 1, enable = 0, fifo_empty = 1, m_ready = 0;
    logic [7:0] fifo_data = 0;
    logic fifo_rden, m_valid, busy;
    logic [7:0] m_data;
    logic [15:0] words_out;
`ifdef FIFO_DRAIN_PARITY_EN
    logic m_parity;
`endif
    fifo_drain_stream dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rden(fifo_rden), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy),
`ifdef FIFO_DRAIN_PARITY_EN
        .m_parity(m_parity),
`endif
        .words_out(words_out)
    );
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int reads = 0, xfers = 0, cyc = 0;
    int first_rd = -1, first_v = -1, first_x = -1, last_x = -1;
    logic [7:0] fq[$], exp_q[$], got[$];
    logic prev_stall = 0;
    logic [7:0] prev_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic load(input int n, input bit rnd);
        for (int i = 1; i <= n; i++) fq.push_back(rnd ? 8'($urandom) : 8'(i));
        fifo_empty = fq.size() == 0;
    endtask

    // one clock: check at negedge, advance FIFO model and scoreboard just after posedge
    task automatic tick();
        logic rd, xf;
        logic [7:0] d;
        @(negedge clk);
        rd = fifo_rden;
        xf = m_valid & m_ready & !rst;
        d = m_data;
        if (!rst) begin
            chk("rden_vs_empty", rd & fifo_empty, 0);
            chk("pending_le2", (reads - xfers) <= 2, 1);
            chk("words_out", words_out, 16'(xfers));
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", d, prev_data);
            end
            if (xf) chk("order", d, exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'hdead);
            if (rd && first_rd < 0) first_rd = cyc;
            if (m_valid && first_v < 0) first_v = cyc;
        end
        if (xf) begin
            got.push_back(d);
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        prev_stall = m_valid & !m_ready & !rst;
        prev_data = d;
        @(posedge clk);
        #1;
        if (rd) begin
            fifo_data = fq.pop_front();
            exp_q.push_back(fifo_data);
            reads++;
        end
        if (xf) xfers++;
        fifo_empty = fq.size() == 0;
        cyc++;
    endtask

    initial begin
        int x0, x1, r0, en_cyc;
        // reset with a non-empty FIFO and enable high
        fq = '{8'd3, 8'd4};
        fifo_empty = 0;
        enable = 1;
        repeat (2) begin
            tick();
            chk("rst_rden", fifo_rden, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_words", words_out, 0);
            chk("rst_busy", busy, 0);
        end
        chk("rst_fifo_untouched", fq.size(), 2);
        enable = 0;
        rst = 0;
        fq.delete();
        fifo_empty = 1;
        tick();
        // full-rate drain of 1..9
        load(9, 0);
        m_ready = 1;
        got.delete();
        first_rd = -1; first_v = -1; first_x = -1;
        enable = 1;
        en_cyc = cyc;
        for (int i = 0; i < 40 && xfers < 9; i++) tick();
        chk("t2_count", xfers, 9);
        chk("t2_words_out", words_out, 9);
        chk("t2_en_to_rden", first_rd - en_cyc, 1);
        chk("t2_rden_to_valid", first_v - first_rd, 2);
        chk("t2_back_to_back", last_x - first_x, 8);
        for (int i = 0; i < got.size(); i++) chk("t2_data", got[i], i + 1);
        // backpressure: only two reads may be outstanding
        m_ready = 0;
        x0 = xfers;
        r0 = reads;
        got.delete();
        load(5, 0);
        repeat (10) tick();
        chk("t3_reads", reads - r0, 2);
        chk("t3_valid", m_valid, 1);
        chk("t3_head", m_data, 1);
        m_ready = 1;
        for (int i = 0; i < 40 && xfers - x0 < 5; i++) tick();
        chk("t3_count", xfers - x0, 5);
        for (int i = 0; i < got.size(); i++) chk("t3_data", got[i], i + 1);
        // stop after the second word, flush, then resume
        x0 = xfers;
        got.delete();
        load(6, 0);
        for (int i = 0; i < 40 && xfers - x0 < 2; i++) tick();
        enable = 0;
        x1 = xfers;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("t4_idle", busy, 0);
        chk("t4_extra_le2", (xfers - x1) <= 2, 1);
        chk("t4_conserved", (xfers - x0) + fq.size(), 6);
        enable = 1;
        for (int i = 0; i < 40 && xfers - x0 < 6; i++) tick();
        chk("t4_count", xfers - x0, 6);
        for (int i = 0; i < got.size(); i++) chk("t4_data", got[i], i + 1);
        // reset with a word buffered and another in flight
        m_ready = 0;
        r0 = reads;
        load(4, 1);
        for (int i = 0; i < 20 && reads - r0 < 2; i++) tick();
        chk("t5_two_reads", reads - r0, 2);
        chk("t5_pre_valid", m_valid, 1);
        rst = 1;
        tick();
        chk("t5_valid", m_valid, 0);
        chk("t5_words", words_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rden", fifo_rden, 0);
        exp_q.delete();
        got.delete();
        reads = 0;
        xfers = 0;
        prev_stall = 0;
        rst = 0;
        tick();
        chk("t5_discarded", m_valid, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) load($urandom_range(1, 3), 1);
            m_ready = 1'($urandom);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            tick();
        end
        enable = 1;
        m_ready = 1;
        for (int i = 0; i < 400 && (fq.size() != 0 || exp_q.size() != 0 || reads != xfers); i++) tick();
        chk("rand_fifo_drained", fq.size(), 0);
        chk("rand_all_delivered", exp_q.size(), 0);
        chk("rand_reads_eq_xfers", reads, xfers);
        chk("rand_words_out", words_out, 16'(xfers));
`ifdef FIFO_DRAIN_PARITY_EN
        m_ready = 0;
        fq.push_back(8'h07);
        fq.push_back(8'h03);
        fifo_empty = 0;
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        chk("par_data7", m_data, 8'h07);
        chk("par_odd", m_parity, 1);
        m_ready = 1;
        tick();
        m_ready = 0;
        chk("par_data3", m_data, 8'h03);
        chk("par_even", m_parity, 0);
        m_ready = 1;
        repeat (4) tick();
        chk("par_idle", m_parity, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
